// File: rtl/ones_pattern_gen.sv
// Serially builds an N-bit word holding exactly clamp(Data) ones, MSB-aligned, and mirrors each bit on w.
// Latency: start sampled at edge t, shifts on edges t+1..t+N, Done from edge t+N onward.
// Backpressure: Done is held while s stays high; the next run can only start after s drops.
module ones_pattern_gen #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          LB,
    input  logic [CW-1:0] Data,
    input  logic          s,
    output logic [N-1:0]  A,
    output logic          w,
    output logic          Busy,
    output logic          Done
);

    localparam int KW = $clog2(N + 1);
    localparam logic [CW-1:0] N_CW    = CW'(N);
    localparam logic [KW-1:0] K_LAST  = KW'(N - 1);

    typedef enum logic [1:0] {
        S1 = 2'd0,
        S2 = 2'd1,
        S3 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] b_q, b_d;
    logic [KW-1:0] k_q, k_d;
    logic [N-1:0]  a_q, a_d;
    logic          w_q, w_d;

    logic [CW-1:0] load_val;
    logic          shift_bit;

    // Requests above the word width saturate silently.
    assign load_val  = (Data > N_CW) ? N_CW : Data;
    assign shift_bit = (b_q != '0);

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        k_d     = k_q;
        a_d     = a_q;
        w_d     = w_q;

        unique case (state_q)
            S1: begin
                if (LB) begin
                    b_d = load_val;
                end
                if (s) begin
                    state_d = S2;
                    k_d     = '0;
                end
            end

            S2: begin
                a_d = {a_q[N-2:0], shift_bit};
                w_d = shift_bit;
                if (shift_bit) begin
                    b_d = b_q - 1'b1;
                end
                // Final shift returns k to zero so it never reaches N.
                if (k_q == K_LAST) begin
                    state_d = S3;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            S3: begin
                if (!s) begin
                    state_d = S1;
                end
            end

            default: begin
                state_d = S1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S1;
            b_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            w_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            k_q     <= k_d;
            a_q     <= a_d;
            w_q     <= w_d;
        end
    end

    assign A    = a_q;
    assign w    = w_q;
    assign Busy = (state_q == S2);
    assign Done = (state_q == S3);

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Randomized bench for ones_pattern_gen: stimulus pushes the expected ones-count per run,
// a negedge monitor collects the serial stream and checks word and stream when Done rises.
module tb_ones_pattern_gen;

    localparam int N  = 4;
    localparam int CW = 3;

    logic          Clk;
    logic          Reset;
    logic          LB;
    logic [CW-1:0] Data;
    logic          s;
    logic [N-1:0]  A;
    logic          w;
    logic          Busy;
    logic          Done;

    int checks;
    int errors;
    int exp_q[$];
    bit wq[$];
    bit prev_busy;
    bit prev_done;
    int model_c;

    ones_pattern_gen #(.N(N), .CW(CW)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .LB   (LB),
        .Data (Data),
        .s    (s),
        .A    (A),
        .w    (w),
        .Busy (Busy),
        .Done (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int clamp(input int d);
        return (d > N) ? N : d;
    endfunction

    // Word with the top c bits set; also the expected serial stream read first-bit-as-MSB.
    function automatic logic [N-1:0] exp_word(input int c);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < c; i++) v[N-1-i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard side: one expected entry per Done rising edge.
    always @(negedge Clk) begin
        logic [N-1:0] got_w;
        int c;
        if (Reset) begin
            wq.delete();
            prev_busy = 1'b0;
            prev_done = Done;
        end else begin
            if (prev_busy) wq.push_back(w);
            if (Done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    c = exp_q.pop_front();
                    check("word_A", A, exp_word(c));
                    check("shift_count", wq.size(), N);
                    got_w = '0;
                    foreach (wq[i]) got_w = {got_w[N-2:0], wq[i]};
                    check("serial_w", got_w, exp_word(c));
                end
                wq.delete();
            end
            prev_busy = Busy;
            prev_done = Done;
        end
    end

    task automatic load(input int d);
        LB   = 1'b1;
        Data = CW'(d);
        s    = 1'b0;
        step();
        LB      = 1'b0;
        model_c = clamp(d);
    endtask

    task automatic do_run(input bit with_load, input int d, input int hold, input bit lb_pulse);
        logic [N-1:0] ew;
        if (with_load) begin
            LB      = 1'b1;
            Data    = CW'(d);
            model_c = clamp(d);
        end
        s = 1'b1;
        exp_q.push_back(model_c);
        ew = exp_word(model_c);
        model_c = 0;
        step();
        check("busy_after_start", Busy, 1);
        for (int j = 0; j < N; j++) begin
            if (lb_pulse && j == 1) begin
                LB   = 1'b1;
                Data = CW'($urandom_range(0, 7));
            end else begin
                LB = 1'b0;
            end
            step();
        end
        LB = 1'b0;
        check("done_after_N", Done, 1);
        check("busy_clear_at_done", Busy, 0);
        for (int h = 0; h < hold; h++) begin
            step();
            check("done_held", Done, 1);
            check("A_held_in_S3", A, ew);
        end
        s = 1'b0;
        step();
        check("done_drop", Done, 0);
        check("A_kept_idle", A, ew);
    endtask

    task automatic reset_mid(input int d);
        LB   = 1'b1;
        Data = CW'(d);
        s    = 1'b1;
        step();
        LB = 1'b0;
        step();
        step();
        Reset = 1'b1;
        step();
        check("midrst_A", A, 0);
        check("midrst_w", w, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_done", Done, 0);
        Reset   = 1'b0;
        s       = 1'b0;
        model_c = 0;
        step();
        check("midrst_idle_busy", Busy, 0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        model_c = 0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        Reset = 1'b1;
        LB    = 1'b0;
        Data  = '0;
        s     = 1'b0;
        step();
        step();
        check("rst_A", A, 0);
        check("rst_w", w, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        Reset = 1'b0;
        step();

        load(3);
        do_run(1'b0, 0, 0, 1'b0);
        load(0);
        do_run(1'b0, 0, 0, 1'b0);
        check("zero_w_last", w, 0);
        load(7);
        do_run(1'b0, 0, 0, 1'b0);
        check("full_w_last", w, 1);
        do_run(1'b1, 2, 0, 1'b1);
        reset_mid(3);
        do_run(1'b1, 4, 5, 1'b0);
        load(1);
        do_run(1'b0, 0, 0, 1'b0);
        // B is consumed by a run, so a bare restart produces zeros.
        do_run(1'b0, 0, 1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            int d;
            int mode;
            d    = $urandom_range(0, 7);
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin
                    load(d);
                    do_run(1'b0, 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                end
                1: do_run(1'b1, d, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                2: do_run(1'b0, 0, $urandom_range(0, 2), 1'b0);
                default: reset_mid(d);
            endcase
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) step();
        end

        step();
        step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
